// File: rtl/alu3_pkg.sv
// Shared types for the 3-bit ALU slice word sequencer: operation codes,
// sequencer states and the slice control bundle.
package alu3_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_RESP  = 2'b10
    } state_e;

    typedef struct packed {
        logic b_inv;
        logic op1;
        logic op0;
        logic x;
    } slice_ctrl_t;

    localparam slice_ctrl_t CTRL_OFF = 4'b0000;

    // SUB seeds the first digit with carry-in 1 to form the two's complement of B
    function automatic logic first_cin(input op_e op);
        return (op == OP_SUB) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic is_arith(input op_e op);
        return ((op == OP_ADD) || (op == OP_SUB)) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/alu3_op_decode.sv
// Combinational mapping from a sequencer operation to the slice control pins.
import alu3_pkg::*;

module alu3_op_decode (
    input  op_e         op,
    output slice_ctrl_t ctrl
);

    // Translate the operation code into slice control bits
    always_comb begin
        ctrl = CTRL_OFF;
        case (op)
            OP_ADD:  ctrl = '{b_inv: 1'b0, op1: 1'b0, op0: 1'b0, x: 1'b1};
            OP_SUB:  ctrl = '{b_inv: 1'b1, op1: 1'b0, op0: 1'b0, x: 1'b1};
            OP_AND:  ctrl = '{b_inv: 1'b0, op1: 1'b1, op0: 1'b0, x: 1'b1};
            OP_XOR:  ctrl = '{b_inv: 1'b0, op1: 1'b1, op0: 1'b1, x: 1'b1};
            default: ctrl = CTRL_OFF;
        endcase
    end

endmodule

// File: rtl/alu3_word_sequencer.sv
// Runs WORDS-digit operations through a 3-bit ALU slice, LSB digit first, chaining carry.
// Optional macro ALU3_SEQ_OVF_EN adds the rsp_ovf_o signed-overflow output.
import alu3_pkg::*;

module alu3_word_sequencer #(
    parameter int WORDS         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [3*WORDS-1:0]   cmd_a_i,
    input  logic [3*WORDS-1:0]   cmd_b_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [3*WORDS-1:0]   rsp_result_o,
    output logic                 rsp_carry_o,
`ifdef ALU3_SEQ_OVF_EN
    output logic                 rsp_ovf_o,
`endif
    output logic [2:0]           alu_a_o,
    output logic [2:0]           alu_b_o,
    output logic                 alu_b_inv_o,
    output logic                 alu_cin_o,
    output logic                 alu_op1_o,
    output logic                 alu_op0_o,
    output logic                 alu_x_o,
    input  logic [2:0]           alu_result_i,
    input  logic                 alu_flag_i
);

    localparam int W   = 3 * WORDS;
    localparam int K_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int S_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [K_W-1:0] K_LAST     = K_W'(WORDS - 1);
    localparam logic [S_W-1:0] S_LAST     = S_W'(SETTLE_CYCLES - 1);
    localparam logic [W-1:0]   DIGIT_MASK = W'(3'b111);

    state_e          state_r,  state_nx_s;
    op_e             op_r,     op_nx_s;
    logic [W-1:0]    a_r,      a_nx_s;
    logic [W-1:0]    b_r,      b_nx_s;
    logic [W-1:0]    result_nx_s;
    logic            carry_r,  carry_nx_s;
    logic [K_W-1:0]  k_r,      k_nx_s;
    logic [S_W-1:0]  settle_r, settle_nx_s;
    logic [31:0]     cap_shift_s;
    logic [31:0]     drv_shift_s;
    logic [W-1:0]    a_sh_s;
    logic [W-1:0]    b_sh_s;
    slice_ctrl_t     ctrl_s;
    slice_ctrl_t     ctrl_nx_s;
    logic [2:0]      alu_a_nx_s;
    logic [2:0]      alu_b_nx_s;
    logic            alu_cin_nx_s;
    logic            rsp_carry_nx_s;
    logic            ovf_nx_s;

    assign cap_shift_s = 32'(k_r) * 32'd3;
    assign drv_shift_s = 32'(k_nx_s) * 32'd3;
    assign a_sh_s      = a_nx_s >> drv_shift_s;
    assign b_sh_s      = b_nx_s >> drv_shift_s;

    // Sequencer next-state: accept, per-digit settle/capture, response handshake
    always_comb begin
        state_nx_s  = state_r;
        op_nx_s     = op_r;
        a_nx_s      = a_r;
        b_nx_s      = b_r;
        k_nx_s      = k_r;
        settle_nx_s = settle_r;
        result_nx_s = rsp_result_o;
        carry_nx_s  = carry_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_nx_s  = S_DRIVE;
                    op_nx_s     = op_e'(cmd_op_i);
                    a_nx_s      = cmd_a_i;
                    b_nx_s      = cmd_b_i;
                    k_nx_s      = '0;
                    settle_nx_s = '0;
                    result_nx_s = '0;
                    carry_nx_s  = 1'b0;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (settle_r == S_LAST) begin
                    result_nx_s = (rsp_result_o & ~(DIGIT_MASK << cap_shift_s))
                                | (W'(alu_result_i) << cap_shift_s);
                    // Slice flag is carry XOR b_inv; undo the inversion to recover true carry
                    carry_nx_s  = alu_flag_i ^ alu_b_inv_o;
                    settle_nx_s = '0;
                    if (k_r == K_LAST) begin
                        state_nx_s = S_RESP;
                        k_nx_s     = '0;
                    end else begin
                        k_nx_s = k_r + K_W'(1);
                    end
                end else begin
                    settle_nx_s = settle_r + S_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_RESP;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    alu3_op_decode u_decode (
        .op   (op_nx_s),
        .ctrl (ctrl_s)
    );

    // Next values of the registered slice pins and response flags
    always_comb begin
        alu_a_nx_s     = 3'b000;
        alu_b_nx_s     = 3'b000;
        alu_cin_nx_s   = 1'b0;
        ctrl_nx_s      = CTRL_OFF;
        rsp_carry_nx_s = 1'b0;
        ovf_nx_s       = 1'b0;
        if (state_nx_s == S_DRIVE) begin
            alu_a_nx_s = a_sh_s[2:0];
            alu_b_nx_s = b_sh_s[2:0];
            ctrl_nx_s  = ctrl_s;
            if (!is_arith(op_nx_s)) begin
                alu_cin_nx_s = 1'b0;
            end else if (k_nx_s == '0) begin
                alu_cin_nx_s = first_cin(op_nx_s);
            end else begin
                alu_cin_nx_s = carry_nx_s;
            end
        end else if ((state_nx_s == S_RESP) && is_arith(op_nx_s)) begin
            rsp_carry_nx_s = carry_nx_s;
            ovf_nx_s = (a_nx_s[W-1] == (b_nx_s[W-1] ^ first_cin(op_nx_s)))
                    && (result_nx_s[W-1] != a_nx_s[W-1]);
        end else begin
            rsp_carry_nx_s = 1'b0;
            ovf_nx_s       = 1'b0;
        end
    end

    // State, operand, result and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            op_r         <= OP_ADD;
            a_r          <= '0;
            b_r          <= '0;
            carry_r      <= 1'b0;
            k_r          <= '0;
            settle_r     <= '0;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_carry_o  <= 1'b0;
            alu_a_o      <= 3'b000;
            alu_b_o      <= 3'b000;
            alu_b_inv_o  <= 1'b0;
            alu_cin_o    <= 1'b0;
            alu_op1_o    <= 1'b0;
            alu_op0_o    <= 1'b0;
            alu_x_o      <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            op_r         <= op_nx_s;
            a_r          <= a_nx_s;
            b_r          <= b_nx_s;
            carry_r      <= carry_nx_s;
            k_r          <= k_nx_s;
            settle_r     <= settle_nx_s;
            cmd_ready_o  <= (state_nx_s == S_IDLE);
            rsp_valid_o  <= (state_nx_s == S_RESP);
            rsp_result_o <= result_nx_s;
            rsp_carry_o  <= rsp_carry_nx_s;
            alu_a_o      <= alu_a_nx_s;
            alu_b_o      <= alu_b_nx_s;
            alu_b_inv_o  <= ctrl_nx_s.b_inv;
            alu_cin_o    <= alu_cin_nx_s;
            alu_op1_o    <= ctrl_nx_s.op1;
            alu_op0_o    <= ctrl_nx_s.op0;
            alu_x_o      <= ctrl_nx_s.x;
        end
    end

`ifdef ALU3_SEQ_OVF_EN
    // Signed-overflow flag, presented alongside the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_ovf_o <= 1'b0;
        end else begin
            rsp_ovf_o <= ovf_nx_s;
        end
    end
`else
    logic ovf_unused_s;
    assign ovf_unused_s = ovf_nx_s;
`endif

endmodule

// File: tb/tb_alu3_word_sequencer.sv
// Randomized self-checking bench for alu3_word_sequencer with a behavioural slice
// and a whole-word arithmetic reference model.
module tb_alu3_word_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [8:0] cmd_a;
    logic [8:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [8:0] rsp_result;
    logic       rsp_carry;
`ifdef ALU3_SEQ_OVF_EN
    logic       rsp_ovf;
`endif
    logic [2:0] alu_a, alu_b, alu_result;
    logic       alu_b_inv, alu_cin, alu_op1, alu_op0, alu_x, alu_flag;
    logic [2:0] slice_bb;
    logic [3:0] slice_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu3_word_sequencer #(.WORDS(3), .SETTLE_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_carry_o  (rsp_carry),
`ifdef ALU3_SEQ_OVF_EN
        .rsp_ovf_o    (rsp_ovf),
`endif
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_b_inv_o  (alu_b_inv),
        .alu_cin_o    (alu_cin),
        .alu_op1_o    (alu_op1),
        .alu_op0_o    (alu_op0),
        .alu_x_o      (alu_x),
        .alu_result_i (alu_result),
        .alu_flag_i   (alu_flag)
    );

    // Behavioural 3-bit slice; logic ops report flag=1 so the sequencer must mask it
    always_comb begin
        slice_bb  = alu_b_inv ? ~alu_b : alu_b;
        slice_sum = {1'b0, alu_a} + {1'b0, slice_bb} + {3'b000, alu_cin};
        case ({alu_op1, alu_op0})
            2'b10:   alu_result = alu_a & slice_bb;
            2'b11:   alu_result = alu_a ^ slice_bb;
            default: alu_result = slice_sum[2:0];
        endcase
        if (!alu_x)       alu_flag = 1'b0;
        else if (alu_op1) alu_flag = 1'b1;
        else              alu_flag = slice_sum[3] ^ alu_b_inv;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: plain 10-bit arithmetic on the full operands
    function automatic void ref_op(input logic [1:0] op, input logic [8:0] a, input logic [8:0] b,
                                   output logic [8:0] r, output logic c, output logic v);
        logic [9:0] s;
        logic       bm;
        case (op)
            2'd0:    s = {1'b0, a} + {1'b0, b};
            2'd1:    s = {1'b0, a} + {1'b0, ~b} + 10'd1;
            2'd2:    s = {1'b0, a & b};
            default: s = {1'b0, a ^ b};
        endcase
        r  = s[8:0];
        c  = (op < 2'd2) ? s[9] : 1'b0;
        bm = (op == 2'd1) ? ~b[8] : b[8];
        v  = (op < 2'd2) && (a[8] == bm) && (r[8] != a[8]);
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [8:0] a, input logic [8:0] b,
                          input int stall);
        logic [8:0] er;
        logic       ec, ev;
        int         cyc;
        ref_op(op, a, b, er, ec, ev);
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("pin_x", 32'(alu_x), 32'd1);
        chk("pin_a0", 32'(alu_a), 32'(a[2:0]));
        chk("pin_b0", 32'(alu_b), 32'(b[2:0]));
        chk("pin_binv", 32'(alu_b_inv), 32'(op == 2'd1));
        chk("pin_cin0", 32'(alu_cin), 32'(op == 2'd1));
        chk("pin_op", 32'({alu_op1, alu_op0}), 32'({op[1], op[1] & op[0]}));
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("latency", 32'(cyc), 32'd6);
        chk("result", 32'(rsp_result), 32'(er));
        chk("carry", 32'(rsp_carry), 32'(ec));
`ifdef ALU3_SEQ_OVF_EN
        chk("ovf", 32'(rsp_ovf), 32'(ev));
`endif
        chk("pins_idle_resp", 32'({alu_a, alu_b, alu_b_inv, alu_cin, alu_op1, alu_op0, alu_x}), 32'd0);
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_result", 32'(rsp_result), 32'(er));
            chk("stall_carry", 32'(rsp_carry), 32'(ec));
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [1:0] rop;
        logic [8:0] ra, rb;
        bit         seen;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 9'd0; cmd_b = 9'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", 32'({rsp_result, rsp_carry}), 32'd0);
        chk("rst_pins", 32'({alu_a, alu_b, alu_b_inv, alu_cin, alu_op1, alu_op0, alu_x}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'd0, 9'h1FF, 9'h001, 0);
        run_op(2'd1, 9'h005, 9'h007, 0);
        run_op(2'd1, 9'h007, 9'h005, 0);
        run_op(2'd2, 9'h1B6, 9'h0F0, 0);
        run_op(2'd3, 9'h1B6, 9'h0F0, 0);
        run_op(2'd0, 9'h0FF, 9'h001, 0);
        run_op(2'd0, 9'h001, 9'h001, 0);
        run_op(2'd0, 9'h123, 9'h0AB, 10);

        // Abort during digit 1: accept edge plus three cycles lands in its settle window
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 9'h0ED; cmd_b = 9'h057;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_pins", 32'({alu_a, alu_b, alu_b_inv, alu_cin, alu_op1, alu_op0, alu_x}), 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        chk("abort_no_rsp", 32'(seen), 32'd0);

        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 9'($urandom);
            rb  = 9'($urandom);
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
